// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline stage with internal data memory and syscall FSM.
//
// Performs the memory access of an instruction leaving EX_MEM (word or
// halfword load/store into a 2^ADDR_W x 32 memory), selects write-back data
// (JAL link > load data > ALU result) and registers it for the register file.
// Syscalls are resolved here: code 1 updates the display register, code 10
// halts the processor until CLR.
//
// Ports:
//   CLK, CLR, EN         clock, synchronous active-high reset, stage advance
//   AluResult            memory byte address / result to write back
//   R1, R2               syscall code ($v0); store data / display arg ($a0)
//   PC_plus_four         JAL link value
//   WAdr                 destination register
//   RegWrite, MemToReg, MemWrite, HalfW, JAL, Syscall   control bits
//   WData_Out, WAdr_Out, RegWrite_Out   registered write-back fields
//   Halt                 high while halted
//   Display              last displayed syscall argument
//   SyscallCount         number of display syscalls (wraps at 2^16)
//   CycleCount           number of active cycles (wraps at 2^32)
module mem_wb_stage #(
    parameter int ADDR_W = 10
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        EN,
    input  logic [31:0] AluResult,
    input  logic [31:0] R1,
    input  logic [31:0] R2,
    input  logic [31:0] PC_plus_four,
    input  logic [4:0]  WAdr,
    input  logic        RegWrite,
    input  logic        MemToReg,
    input  logic        MemWrite,
    input  logic        HalfW,
    input  logic        JAL,
    input  logic        Syscall,
    output logic [31:0] WData_Out,
    output logic [4:0]  WAdr_Out,
    output logic        RegWrite_Out,
    output logic        Halt,
    output logic [31:0] Display,
    output logic [15:0] SyscallCount,
    output logic [31:0] CycleCount
);

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    state_t state_q, state_d;

    logic [31:0]       mem [0:(1 << ADDR_W) - 1];
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       rd_word;
    logic [31:0]       load_data;
    logic [31:0]       wb_data;
    logic [31:0]       mem_wdata;
    logic              active;
    logic              mem_we;
    logic              sys_halt;
    logic              sys_display;
    logic              regwrite_q;
    logic              unused_addr_bits;

    // Byte offset bit 0 and the address bits above the memory are don't-care.
    assign unused_addr_bits = ^{AluResult[31:ADDR_W+2], AluResult[0]};

    assign word_idx = AluResult[ADDR_W+1:2];
    assign rd_word  = mem[word_idx];
    assign active   = EN && (state_q == RUN) && !CLR;
    assign mem_we   = active && MemWrite;

    assign sys_halt    = Syscall && (R1 == 32'd10);
    assign sys_display = Syscall && (R1 == 32'd1);

    always_comb begin
        load_data = rd_word;
        if (HalfW) begin
            load_data = AluResult[1] ? {16'h0000, rd_word[31:16]}
                                     : {16'h0000, rd_word[15:0]};
        end
    end

    always_comb begin
        wb_data = AluResult;
        if (JAL) begin
            wb_data = PC_plus_four;
        end else if (MemToReg) begin
            wb_data = load_data;
        end
    end

    // Halfword stores merge into the current word so the other half is kept.
    always_comb begin
        mem_wdata = R2;
        if (HalfW) begin
            mem_wdata = AluResult[1] ? {R2[15:0], rd_word[15:0]}
                                     : {rd_word[31:16], R2[15:0]};
        end
    end

    // Read is combinational from pre-edge contents, so a same-cycle
    // load/store to one word sees the old value.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[word_idx] <= mem_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        if (active && sys_halt) begin
            state_d = HALTED;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            WData_Out    <= '0;
            WAdr_Out     <= '0;
            regwrite_q   <= 1'b0;
            Display      <= '0;
            SyscallCount <= '0;
            CycleCount   <= '0;
        end else if (active) begin
            WData_Out  <= wb_data;
            WAdr_Out   <= WAdr;
            regwrite_q <= RegWrite;
            CycleCount <= CycleCount + 32'd1;
            if (sys_display) begin
                Display      <= R2;
                SyscallCount <= SyscallCount + 16'd1;
            end
        end
    end

    // The halting syscall's own RegWrite is latched, but must not reach the
    // register file once halted, so it is masked rather than cleared.
    assign Halt         = (state_q == HALTED);
    assign RegWrite_Out = regwrite_q && !Halt;

endmodule
